// File: rtl/fifo_checker_pkg.sv
// Shared types and defaults for the FIFO stream checker and its pacer.
package fifo_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } chk_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/fifo_check_pacer.sv
// Inter-pop gap counter and RUN-idle watchdog for the FIFO stream checker.
module fifo_check_pacer
  import fifo_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       MCLK,
  input  logic       nRST,
  input  logic       clear,
  input  logic       run,
  input  logic       pop,
  input  logic       cmp,
  input  logic [3:0] gap,
  output logic       gap_zero_c,
  output logic       timeout_c
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [3:0]      gap_cnt;
  logic [TO_W-1:0] idle_cnt;

  // Gap reloads on every pop; idle count restarts on any compare or outside RUN.
  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      gap_cnt  <= 4'd0;
      idle_cnt <= '0;
    end else begin
      if (clear)                gap_cnt <= 4'd0;
      else if (pop)             gap_cnt <= gap;
      else if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;

      if (!run || cmp)                     idle_cnt <= '0;
      else if (idle_cnt != TO_W'(TIMEOUT)) idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  assign gap_zero_c = (gap_cnt == 4'd0);
  // A compare in the same cycle wins over the watchdog.
  assign timeout_c  = run && !cmp && (idle_cnt == TO_W'(TIMEOUT));

endmodule

// File: rtl/fifo_stream_checker.sv
// Pops an arithmetic sequence out of a FIFO and checks each word, counting
// matches/errors with self-resynchronising expected value and an idle watchdog.
module fifo_stream_checker
  import fifo_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FWFT       = 1,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  nCLR,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] SEED,
  input  logic [DATA_WIDTH-1:0] STEP,
  input  logic [CNT_WIDTH-1:0]  TARGET,
  input  logic [3:0]            GAP,
  input  logic                  EMPTY,
  output logic                  nRE,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  INTR,
  output logic                  TIMED_OUT,
  output logic [CNT_WIDTH-1:0]  MATCH_CNT,
  output logic [CNT_WIDTH-1:0]  ERR_CNT,
  output logic [DATA_WIDTH-1:0] FIRST_ERR_DATA,
  output logic [CNT_WIDTH-1:0]  FIRST_ERR_IDX
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  chk_state_e            state;
  logic [DATA_WIDTH-1:0] expected;
  logic [DATA_WIDTH-1:0] step_r;
  logic [CNT_WIDTH-1:0]  target_r;
  logic [CNT_WIDTH-1:0]  pop_cnt;
  logic [CNT_WIDTH-1:0]  cmp_cnt;
  logic [3:0]            gap_r;
  logic                  rd_pend;
  logic                  have_err;

  logic start_c;
  logic pop_c;
  logic cmp_c;
  logic run_c;
  logic gap_zero_c;
  logic timeout_c;

  assign run_c   = (state == ST_RUN);
  assign start_c = START && (state != ST_RUN);
  // EMPTY feeds the strobe directly so a pop can never follow a stale flag.
  assign pop_c   = run_c && !EMPTY && gap_zero_c && !rd_pend && (pop_cnt < target_r);
  assign nRE     = ~pop_c;
  assign cmp_c   = (FWFT != 0) ? pop_c : rd_pend;

  fifo_check_pacer #(
    .TIMEOUT (TIMEOUT)
  ) u_pacer (
    .MCLK       (CLK),
    .nRST       (nCLR),
    .clear      (start_c),
    .run        (run_c),
    .pop        (pop_c),
    .cmp        (cmp_c),
    .gap        (gap_r),
    .gap_zero_c (gap_zero_c),
    .timeout_c  (timeout_c)
  );

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state          <= ST_IDLE;
      expected       <= '0;
      step_r         <= '0;
      target_r       <= '0;
      pop_cnt        <= '0;
      cmp_cnt        <= '0;
      gap_r          <= 4'd0;
      rd_pend        <= 1'b0;
      have_err       <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      INTR           <= 1'b0;
      TIMED_OUT      <= 1'b0;
      MATCH_CNT      <= '0;
      ERR_CNT        <= '0;
      FIRST_ERR_DATA <= '0;
      FIRST_ERR_IDX  <= '0;
    end else begin
      INTR <= 1'b0;
      if (start_c) begin
        state          <= ST_RUN;
        expected       <= SEED;
        step_r         <= STEP;
        target_r       <= TARGET;
        gap_r          <= GAP;
        pop_cnt        <= '0;
        cmp_cnt        <= '0;
        rd_pend        <= 1'b0;
        have_err       <= 1'b0;
        BUSY           <= 1'b1;
        DONE           <= 1'b0;
        TIMED_OUT      <= 1'b0;
        MATCH_CNT      <= '0;
        ERR_CNT        <= '0;
        FIRST_ERR_DATA <= '0;
        FIRST_ERR_IDX  <= '0;
      end else begin
        case (state)
          ST_RUN: begin
            if (pop_c) pop_cnt <= pop_cnt + CNT_WIDTH'(1);
            rd_pend <= (FWFT == 0) && pop_c;

            if (cmp_c) begin
              cmp_cnt  <= cmp_cnt + CNT_WIDTH'(1);
              expected <= DIN + step_r;
              if (DIN == expected) begin
                if (MATCH_CNT != CNT_MAX) MATCH_CNT <= MATCH_CNT + CNT_WIDTH'(1);
              end else begin
                if (ERR_CNT != CNT_MAX) ERR_CNT <= ERR_CNT + CNT_WIDTH'(1);
                if (!have_err) begin
                  have_err       <= 1'b1;
                  FIRST_ERR_DATA <= DIN;
                  FIRST_ERR_IDX  <= cmp_cnt;
                end
              end
            end

            if ((cmp_cnt == target_r) || timeout_c) begin
              state     <= ST_FINISH;
              DONE      <= 1'b1;
              INTR      <= 1'b1;
              TIMED_OUT <= (cmp_cnt != target_r);
            end
          end
          ST_FINISH: begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fifo_stream_checker.md
FIFO_STREAM_CHECKER -- requirements
Module: fifo_stream_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of checked data.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of target, match and error counters.
REQ-003 SHALL have parameter FWFT, default 1: 1 = DIN valid while EMPTY low; 0 = DIN valid one cycle after pop.
REQ-004 SHALL have parameter TIMEOUT, default 256, idle cycles in RUN before abort.
REQ-005 SHALL have ports: CLK  in  1  clock, rising edge.
REQ-006 SHALL have ports: nCLR  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: START  in  1  one-cycle pulse, begins a check run.
REQ-008 SHALL have ports: SEED  in  DATA_WIDTH  first expected word, sampled on START.
REQ-009 SHALL have ports: STEP  in  DATA_WIDTH  expected increment, sampled on START.
REQ-010 SHALL have ports: TARGET  in  CNT_WIDTH  words to check, sampled on START; 0 means complete immediately.
REQ-011 SHALL have ports: GAP  in  4  idle cycles forced between pops, sampled on START.
REQ-012 SHALL have ports: EMPTY  in  1  FIFO empty flag; nRE  out  1  active-low pop strobe; DIN  in  DATA_WIDTH  FIFO DOUT.
REQ-013 SHALL have ports: BUSY  out  1; DONE  out  1 level; INTR  out  1 one-cycle pulse; TIMED_OUT  out  1.
REQ-014 SHALL have ports: MATCH_CNT, ERR_CNT  out  CNT_WIDTH; FIRST_ERR_DATA  out  DATA_WIDTH; FIRST_ERR_IDX  out  CNT_WIDTH.

Function
REQ-015 SHALL implement states IDLE, RUN, FINISH; IDLE->RUN on START, RUN->FINISH on completion or timeout, FINISH->IDLE after one cycle, FINISH->RUN directly on START.
REQ-016 SHALL, on START in IDLE or FINISH, load SEED/STEP/TARGET/GAP, clear counters, DONE, TIMED_OUT, FIRST_ERR_*; START in RUN is ignored.
REQ-017 SHALL drive nRE low only in RUN, when EMPTY low, gap counter zero, no FWFT=0 read outstanding, and issued pops < TARGET.
REQ-018 SHALL never drive nRE low while EMPTY is high (no underflow pop).
REQ-019 SHALL, after each pop, reload the gap counter with GAP and decrement it once per cycle to zero.
REQ-020 SHALL compare DIN against expected on the pop cycle (FWFT=1) or the following cycle (FWFT=0).
REQ-021 SHALL on match increment MATCH_CNT; on mismatch increment ERR_CNT and, if first error, capture DIN and word index (0-based).
REQ-022 SHALL after every compare set expected = compared DIN + STEP (resynchronise), modulo 2^DATA_WIDTH.
REQ-023 SHALL saturate MATCH_CNT and ERR_CNT at all-ones.
REQ-024 SHALL complete when MATCH_CNT+ERR_CNT equals TARGET; TARGET=0 completes one cycle after START.
REQ-025 SHALL count consecutive RUN cycles without a compare; reaching TIMEOUT sets TIMED_OUT and completes.
REQ-026 SHALL on completion enter FINISH, pulse INTR one cycle, set DONE until next START.
REQ-027 SHALL drive BUSY high in RUN and FINISH, low in IDLE.

Reset
REQ-028 SHALL on nCLR low asynchronously enter IDLE, drive nRE high, BUSY/DONE/INTR/TIMED_OUT low, all counters, FIRST_ERR_* and expected to zero.
REQ-029 SHALL abandon any run on mid-operation reset; no pop issued in the first cycle after release.

Structure
REQ-030 SHALL place state enum and default TIMEOUT in shared package fifo_checker_pkg.
REQ-031 SHALL implement gap and timeout counting in sub-module fifo_check_pacer.

Verification
REQ-032 SHALL cover: FiFo depth 2 fed 0..4, SEED=0 STEP=1 TARGET=5 GAP=0 -> MATCH_CNT=5, ERR_CNT=0, INTR once.
REQ-033 SHALL cover: feed 0,1,7,8, SEED=0 STEP=1 TARGET=4 -> ERR_CNT=1, FIRST_ERR_DATA=7, FIRST_ERR_IDX=2, MATCH_CNT=3.
REQ-034 SHALL cover: GAP=3 with writer continuous -> pops 4 cycles apart, FULL asserted, no lost words, ERR_CNT=0.
REQ-035 SHALL cover: TARGET=3, only 2 words written, TIMEOUT=16 -> TIMED_OUT=1, MATCH_CNT=2, DONE=1.
REQ-036 SHALL cover: SEED=FFFFFFFE STEP=1 TARGET=3, data FFFFFFFE,FFFFFFFF,0 -> ERR_CNT=0 (wrap).
REQ-037 SHALL cover: nCLR pulsed mid-run -> all outputs zero, nRE high, START ignored during reset.
